// File: rtl/execute_cycle_if.sv
// Execute-stage bundle: decode-stage inputs in, memory-stage register and branch/stall outputs out.
// master drives the E-stage side (pipeline/bench); slave is the execute stage itself.
interface execute_cycle_if;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [2:0]  ALUControlE;
    logic        MulDivE;
    logic [1:0]  MulDivOpE;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic [31:0] ResultW;

    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE,
               MulDivE, MulDivOpE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
               ForwardA_E, ForwardB_E, ResultW,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE,
               MulDivE, MulDivOpE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
               ForwardA_E, ForwardB_E, ResultW,
        output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_cycle.sv
// Pipeline execute stage: forwarding muxes, ALU, branch resolution, an iterative 32-step
// unsigned multiply/divide unit that stalls upstream, and the E/M pipeline register.
module execute_cycle #(
    parameter int MULDIV_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    execute_cycle_if.slave bus
);

    localparam logic MD_EN = (MULDIV_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opnd;

    logic        r_reg_write_m;
    logic        r_mem_write_m;
    logic        r_result_src_m;
    logic [4:0]  r_rd_m;
    logic [31:0] r_pc_plus4_m;
    logic [31:0] r_write_data_m;
    logic [31:0] r_alu_result_m;

    logic [31:0] w_src_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_src_b;
    logic [31:0] w_alu_result;
    logic        w_zero;
    logic        w_stall;
    logic        w_start;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_md_result;

    function automatic logic [31:0] fwd_sel(
        input logic [1:0]  sel,
        input logic [31:0] rd_val,
        input logic [31:0] result_w,
        input logic [31:0] alu_m
    );
        case (sel)
            2'b01:   fwd_sel = result_w;
            2'b10:   fwd_sel = alu_m;
            default: fwd_sel = rd_val;
        endcase
    endfunction

    assign w_src_a = fwd_sel(bus.ForwardA_E, bus.RD1_E, bus.ResultW, r_alu_result_m);
    assign w_fwd_b = fwd_sel(bus.ForwardB_E, bus.RD2_E, bus.ResultW, r_alu_result_m);
    assign w_src_b = bus.ALUSrcE ? bus.Imm_Ext_E : w_fwd_b;

    // ALU; unused operation codes deliberately yield zero
    always_comb begin
        w_alu_result = 32'd0;
        case (bus.ALUControlE)
            3'b000:  w_alu_result = w_src_a + w_src_b;
            3'b001:  w_alu_result = w_src_a - w_src_b;
            3'b010:  w_alu_result = w_src_a & w_src_b;
            3'b011:  w_alu_result = w_src_a | w_src_b;
            3'b101:  w_alu_result = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
            default: w_alu_result = 32'd0;
        endcase
    end

    assign w_zero        = (w_alu_result == 32'd0);
    assign bus.PCSrcE    = bus.BranchE & w_zero;
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

    // Stall is forced low while reset is held so upstream never freezes on a dead unit
    assign w_start = MD_EN & bus.MulDivE & (r_state == S_IDLE);
    assign w_stall = rst & (w_start | (MD_EN & (r_state == S_RUN)));
    assign bus.StallE = w_stall;

    // One iteration: hi:lo is product (mul) or remainder:quotient (div)
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
        w_div_shift = {r_hi, r_lo[31]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_div_ge    = w_div_shift[32] | ~w_div_diff[32];
        if (r_op[1] == 1'b0) begin
            w_hi_nxt = w_mul_sum[32:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[31:1]};
        end else if (w_div_ge) begin
            w_hi_nxt = w_div_diff[31:0];
            w_lo_nxt = {r_lo[30:0], 1'b1};
        end else begin
            w_hi_nxt = w_div_shift[31:0];
            w_lo_nxt = {r_lo[30:0], 1'b0};
        end
    end

    // MUL/DIVU read the low half, MULHU/REMU the high half
    assign w_md_result = r_op[0] ? r_hi : r_lo;

    // Multiply/divide sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_op    <= 2'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_opnd  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op  <= bus.MulDivOpE;
                        r_hi  <= 32'd0;
                        r_cnt <= 5'd0;
                        if (bus.MulDivOpE[1]) begin
                            r_lo   <= w_src_a;
                            r_opnd <= w_src_b;
                        end else begin
                            r_lo   <= w_src_b;
                            r_opnd <= w_src_a;
                        end
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // E/M pipeline register; a stall inserts a bubble and holds the data fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= 1'b0;
            r_rd_m         <= 5'd0;
            r_pc_plus4_m   <= 32'd0;
            r_write_data_m <= 32'd0;
            r_alu_result_m <= 32'd0;
        end else if (w_stall) begin
            r_reg_write_m <= 1'b0;
            r_mem_write_m <= 1'b0;
        end else begin
            r_reg_write_m  <= bus.RegWriteE;
            r_mem_write_m  <= bus.MemWriteE;
            r_result_src_m <= bus.ResultSrcE;
            r_rd_m         <= bus.RD_E;
            r_pc_plus4_m   <= bus.PCPlus4E;
            r_write_data_m <= w_fwd_b;
            r_alu_result_m <= (r_state == S_DONE) ? w_md_result : w_alu_result;
        end
    end

    assign bus.RegWriteM   = r_reg_write_m;
    assign bus.MemWriteM   = r_mem_write_m;
    assign bus.ResultSrcM  = r_result_src_m;
    assign bus.RD_M        = r_rd_m;
    assign bus.PCPlus4M    = r_pc_plus4_m;
    assign bus.WriteDataM  = r_write_data_m;
    assign bus.ALU_ResultM = r_alu_result_m;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: expected M-stage contents are queued when an
// instruction is driven and compared when the E/M register captures it.
module tb_execute_cycle;

    logic clk = 1'b0;
    logic rst = 1'b0;

    execute_cycle_if bus ();

    execute_cycle #(.MULDIV_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        rs;
        logic [31:0] wd;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_last;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd_val);
        if (sel == 2'b01) return bus.ResultW;
        if (sel == 2'b10) return m_last.alu;
        return rd_val;
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] md_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic set_nop();
        bus.RegWriteE = 1'b0;  bus.MemWriteE = 1'b0;  bus.ResultSrcE = 1'b0;
        bus.BranchE = 1'b0;    bus.ALUSrcE = 1'b0;    bus.ALUControlE = 3'd0;
        bus.MulDivE = 1'b0;    bus.MulDivOpE = 2'd0;
        bus.RD1_E = 32'd0;     bus.RD2_E = 32'd0;     bus.Imm_Ext_E = 32'd0;
        bus.PCE = 32'd0;       bus.PCPlus4E = 32'd0;  bus.RD_E = 5'd0;
        bus.ForwardA_E = 2'd0; bus.ForwardB_E = 2'd0; bus.ResultW = 32'd0;
    endtask

    // Issue the ALU instruction currently on the bus (called just after a negedge)
    task automatic exec_alu();
        exp_t e, g;
        logic [31:0] a, bf, b;
        a  = fwd(bus.ForwardA_E, bus.RD1_E);
        bf = fwd(bus.ForwardB_E, bus.RD2_E);
        b  = bus.ALUSrcE ? bus.Imm_Ext_E : bf;
        e  = '{alu: alu_model(bus.ALUControlE, a, b), rd: bus.RD_E, rw: bus.RegWriteE,
               mw: bus.MemWriteE, rs: bus.ResultSrcE, wd: bf, pc4: bus.PCPlus4E};
        sb_q.push_back(e);
        @(posedge clk); #1;
        g = sb_q.pop_front();
        checks++;
        if (bus.ALU_ResultM !== g.alu) begin
            errors++; $display("FAIL alu_result got %h exp %h", bus.ALU_ResultM, g.alu);
        end
        checks++;
        if ({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M} !== {g.rw, g.mw, g.rs, g.rd}) begin
            errors++; $display("FAIL alu_ctrl got %b exp %b",
                {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M}, {g.rw, g.mw, g.rs, g.rd});
        end
        checks++;
        if ({bus.PCPlus4M, bus.WriteDataM} !== {g.pc4, g.wd}) begin
            errors++; $display("FAIL alu_data got %h exp %h", {bus.PCPlus4M, bus.WriteDataM}, {g.pc4, g.wd});
        end
        m_last = g;
        @(negedge clk);
    endtask

    // Issue one mul/div op, count stall cycles, check bubbles, then check the DONE capture
    task automatic run_muldiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic scramble);
        exp_t e, g;
        int stalls;
        logic bubble_ok;
        set_nop();
        bus.MulDivE = 1'b1; bus.MulDivOpE = op; bus.RD1_E = a; bus.RD2_E = b;
        bus.RegWriteE = 1'b1; bus.RD_E = 5'd9; bus.PCPlus4E = 32'h0000_0400;
        e = '{alu: md_model(op, a, b), rd: 5'd9, rw: 1'b1, mw: 1'b0, rs: 1'b0, wd: b, pc4: 32'h0000_0400};
        sb_q.push_back(e);
        stalls = 0;
        bubble_ok = 1'b1;
        #1;
        while (bus.StallE === 1'b1 && stalls < 60) begin
            stalls++;
            @(posedge clk); #1;
            if (bus.RegWriteM !== 1'b0 || bus.MemWriteM !== 1'b0 || bus.ALU_ResultM !== m_last.alu ||
                bus.RD_M !== m_last.rd || bus.PCPlus4M !== m_last.pc4 || bus.WriteDataM !== m_last.wd)
                bubble_ok = 1'b0;
            if (scramble) begin
                bus.ForwardA_E = 2'b01; bus.ResultW = $urandom; bus.ALUSrcE = 1'b1; bus.Imm_Ext_E = $urandom;
            end
            @(negedge clk); #1;
        end
        checks++;
        if (stalls != 33) begin
            errors++; $display("FAIL md_stall_cycles op %0d got %0d exp 33", op, stalls);
        end
        checks++;
        if (!bubble_ok) begin
            errors++; $display("FAIL md_bubble op %0d got a non-bubble or changed field during stall exp bubble", op);
        end
        @(posedge clk); #1;
        g = sb_q.pop_front();
        checks++;
        if (bus.ALU_ResultM !== g.alu) begin
            errors++; $display("FAIL md_result op %0d a %h b %h got %h exp %h", op, a, b, bus.ALU_ResultM, g.alu);
        end
        checks++;
        if ({bus.RegWriteM, bus.RD_M, bus.WriteDataM, bus.PCPlus4M} !== {g.rw, g.rd, g.wd, g.pc4}) begin
            errors++; $display("FAIL md_fields got %h exp %h",
                {bus.RegWriteM, bus.RD_M, bus.WriteDataM, bus.PCPlus4M}, {g.rw, g.rd, g.wd, g.pc4});
        end
        m_last = g;
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_nop();
        bus.RegWriteE = 1'b1; bus.RD1_E = 32'd1; bus.RD_E = 5'd4; bus.PCPlus4E = 32'h44;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M, bus.PCPlus4M, bus.WriteDataM, bus.ALU_ResultM} !== 102'd0) begin
            errors++; $display("FAIL reset_m_outputs got %h exp 0",
                {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M, bus.PCPlus4M, bus.WriteDataM, bus.ALU_ResultM});
        end
        checks++;
        if (bus.StallE !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b exp 0", bus.StallE);
        end
        m_last = '{default: '0};
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add();
        set_nop();
        bus.RD1_E = 32'd5; bus.RD2_E = 32'd7; bus.RegWriteE = 1'b1; bus.RD_E = 5'd3; bus.PCPlus4E = 32'h104;
        exec_alu();
        checks++;
        if ({bus.ALU_ResultM, bus.RD_M, bus.RegWriteM} !== {32'd12, 5'd3, 1'b1}) begin
            errors++; $display("FAIL add_basic got %h/%0d/%b exp 12/3/1", bus.ALU_ResultM, bus.RD_M, bus.RegWriteM);
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0]  ct [0:9];
        logic [31:0] av [0:9];
        logic [31:0] bv [0:9];
        ct = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd5, 3'd4, 3'd6, 3'd7};
        av = '{32'hFFFF_FFFF, 32'd0, 32'hF0F0_F0F0, 32'hF0F0_0000, 32'hFFFF_FFFF,
               32'd1, 32'h8000_0000, 32'd3, 32'd3, 32'd3};
        bv = '{32'd1, 32'd1, 32'hFF00_FF00, 32'h0000_0F0F, 32'd1,
               32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd4, 32'd4, 32'd4};
        for (int i = 0; i < 10; i++) begin
            set_nop();
            bus.ALUControlE = ct[i]; bus.RD1_E = av[i]; bus.RD2_E = bv[i];
            bus.RegWriteE = 1'b1; bus.RD_E = 5'(i + 1); bus.PCPlus4E = 32'(i * 4);
            exec_alu();
        end
        set_nop();
        bus.ALUSrcE = 1'b1; bus.RD1_E = 32'd10; bus.Imm_Ext_E = 32'h100; bus.RD2_E = 32'hABCD;
        bus.MemWriteE = 1'b1; bus.ResultSrcE = 1'b1; bus.RD_E = 5'd31; bus.PCPlus4E = 32'h208;
        exec_alu();
        for (int i = 0; i < 6; i++) begin
            set_nop();
            bus.ALUControlE = 3'($urandom_range(0, 7)); bus.RD1_E = $urandom; bus.RD2_E = $urandom;
            bus.ForwardA_E = 2'($urandom_range(0, 3)); bus.ForwardB_E = 2'($urandom_range(0, 3));
            bus.ResultW = $urandom; bus.RegWriteE = 1'($urandom_range(0, 1)); bus.RD_E = 5'($urandom_range(0, 31));
            bus.PCPlus4E = $urandom;
            exec_alu();
        end
    endtask

    task automatic test_branch();
        set_nop();
        bus.BranchE = 1'b1; bus.ALUControlE = 3'b001; bus.RD1_E = 32'd9; bus.RD2_E = 32'd9;
        bus.PCE = 32'h100; bus.Imm_Ext_E = 32'h20;
        #1;
        checks++;
        if ({bus.PCSrcE, bus.PCTargetE} !== {1'b1, 32'h120}) begin
            errors++; $display("FAIL branch_taken got %b/%h exp 1/00000120", bus.PCSrcE, bus.PCTargetE);
        end
        bus.RD2_E = 32'd8; #1;
        checks++;
        if (bus.PCSrcE !== 1'b0) begin
            errors++; $display("FAIL branch_not_taken got %b exp 0", bus.PCSrcE);
        end
        bus.RD2_E = 32'd9; bus.BranchE = 1'b0; #1;
        checks++;
        if (bus.PCSrcE !== 1'b0) begin
            errors++; $display("FAIL branch_disabled got %b exp 0", bus.PCSrcE);
        end
        bus.PCE = 32'hFFFF_FFF0; #1;
        checks++;
        if (bus.PCTargetE !== 32'h0000_0010) begin
            errors++; $display("FAIL branch_target_wrap got %h exp 00000010", bus.PCTargetE);
        end
        exec_alu();
    endtask

    task automatic test_forward();
        set_nop();
        bus.RD1_E = 32'h10; bus.RegWriteE = 1'b1; bus.RD_E = 5'd1;
        exec_alu();
        set_nop();
        bus.ForwardA_E = 2'b10; bus.RD2_E = 32'd1; bus.RegWriteE = 1'b1; bus.RD_E = 5'd2;
        exec_alu();
        checks++;
        if (bus.ALU_ResultM !== 32'h11) begin
            errors++; $display("FAIL fwd_a_mem got %h exp 00000011", bus.ALU_ResultM);
        end
        set_nop();
        bus.ForwardA_E = 2'b01; bus.ResultW = 32'h20; bus.RD2_E = 32'd1; bus.RegWriteE = 1'b1;
        exec_alu();
        checks++;
        if (bus.ALU_ResultM !== 32'h21) begin
            errors++; $display("FAIL fwd_a_wb got %h exp 00000021", bus.ALU_ResultM);
        end
        set_nop();
        bus.ALUControlE = 3'b001; bus.RD1_E = 32'h100; bus.ForwardB_E = 2'b10; bus.RD2_E = 32'h5;
        exec_alu();
        set_nop();
        bus.ForwardA_E = 2'b11; bus.RD1_E = 32'h7; bus.ResultW = 32'h999; bus.ForwardB_E = 2'b01; bus.MemWriteE = 1'b1;
        exec_alu();
    endtask

    task automatic test_muldiv();
        run_muldiv(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_muldiv(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_muldiv(2'd2, 32'd100, 32'd7, 1'b0);
        run_muldiv(2'd3, 32'd100, 32'd7, 1'b0);
        run_muldiv(2'd2, 32'h1234_5678, 32'd0, 1'b0);
        run_muldiv(2'd3, 32'd5, 32'd0, 1'b0);
        run_muldiv(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        run_muldiv(2'd2, 32'hFFFF_FFF0, 32'h0000_1235, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            set_nop();
            bus.RD1_E = 32'(i * 100); bus.RD2_E = 32'd1; bus.RegWriteE = 1'b1; bus.RD_E = 5'(i + 10);
            bus.ForwardB_E = (i > 0) ? 2'b10 : 2'b00;
            exec_alu();
        end
        run_muldiv(2'd3, 32'hDEAD_BEEF, 32'h0001_0001, 1'b0);
        run_muldiv(2'd1, 32'h8000_0001, 32'h8000_0001, 1'b0);
        set_nop();
        bus.ALUControlE = 3'b011; bus.ForwardA_E = 2'b10; bus.RD2_E = 32'h1; bus.RegWriteE = 1'b1;
        exec_alu();
    endtask

    task automatic test_reset_midrun();
        set_nop();
        bus.MulDivE = 1'b1; bus.RD1_E = 32'd3; bus.RD2_E = 32'd4; bus.RegWriteE = 1'b1; bus.PCPlus4E = 32'h200;
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.StallE !== 1'b0) begin
            errors++; $display("FAIL midrun_reset_stall got %b exp 0", bus.StallE);
        end
        checks++;
        if ({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M, bus.PCPlus4M, bus.WriteDataM, bus.ALU_ResultM} !== 102'd0) begin
            errors++; $display("FAIL midrun_reset_m got %h exp 0",
                {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M, bus.PCPlus4M, bus.WriteDataM, bus.ALU_ResultM});
        end
        m_last = '{default: '0};
        @(negedge clk);
        rst = 1'b1;
        set_nop();
        bus.RD1_E = 32'd40; bus.RD2_E = 32'd2; bus.RegWriteE = 1'b1; bus.RD_E = 5'd6; bus.PCPlus4E = 32'h300;
        exec_alu();
        run_muldiv(2'd0, 32'd3, 32'd4, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_forward();
        test_muldiv();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 The block SHALL have one parameter: MULDIV_EN, default 1, meaning that the iterative multiply/divide unit is present (0 means MulDivE is ignored and StallE is held at 0).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE  in  1 each  decode-stage control bits.
REQ-005 ALUControlE  in  3  ALU operation select.
REQ-006 MulDivE  in  1  selects the mul/div unit instead of the ALU.
REQ-007 MulDivOpE  in  2  mul/div operation select.
REQ-008 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands, immediate, and PC values.
REQ-009 RD_E  in  5  destination register.
REQ-010 ForwardA_E, ForwardB_E  in  2 each  operand forwarding select.
REQ-011 ResultW  in  32  writeback result, used for forwarding.
REQ-012 PCSrcE  out  1  branch taken.
REQ-013 PCTargetE  out  32  branch target.
REQ-014 StallE  out  1  the mul/div unit is busy, so upstream holds its stages.
REQ-015 RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control bits for the memory stage.
REQ-016 RD_M  out  5  registered destination register.
REQ-017 PCPlus4M, WriteDataM, ALU_ResultM  out  32 each  registered data for the memory stage.

Function
REQ-018 SrcA SHALL be: RD1_E when ForwardA_E=00, ResultW when 01, ALU_ResultM when 10, and RD1_E when 11.
REQ-019 The forwarded B value SHALL be selected the same way using RD2_E and ForwardB_E; WriteData SHALL equal this forwarded B value.
REQ-020 SrcB SHALL be Imm_Ext_E when ALUSrcE=1, else the forwarded B value.
REQ-021 ALU operations SHALL be: 000 add, 001 sub, 010 and, 011 or, 101 signed slt (result 1 or 0).
REQ-022 The ALU SHALL produce 0 for any other ALUControlE code.
REQ-023 All ALU arithmetic SHALL be modulo 2^32, with the carry discarded.
REQ-024 Zero SHALL be 1 when the ALU result is all zeros; PCSrcE SHALL equal BranchE AND Zero.
REQ-025 PCTargetE SHALL equal PCE + Imm_Ext_E modulo 2^32, combinationally.
REQ-026 Mul/div operations SHALL be unsigned: 00 MUL (low 32 bits of the product), 01 MULHU (high 32 bits), 10 DIVU, 11 REMU.
REQ-027 Divide by zero SHALL give DIVU = 32'hFFFFFFFF and REMU = dividend; no exception is raised.
REQ-028 The mul/div FSM SHALL have three states: IDLE, RUN, DONE.
REQ-029 From IDLE with MulDivE=1, the FSM SHALL latch SrcA and SrcB, clear the 5-bit iteration counter, and move to RUN.
REQ-030 In RUN, the FSM SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle; after counter value 31 it SHALL move to DONE.
REQ-031 In DONE, the FSM SHALL present the result and return to IDLE on the next edge.
REQ-032 StallE SHALL be combinational: 1 when (state IDLE and MulDivE=1) or state RUN, else 0.
REQ-033 A mul/div instruction SHALL therefore occupy execute for exactly 34 cycles (1 IDLE + 32 RUN + 1 DONE), with StallE high for the first 33.
REQ-034 While StallE=1, the E/M register SHALL load a bubble: RegWriteM=0 and MemWriteM=0, with all other M outputs holding their previous values.
REQ-035 While StallE=0, the E/M register SHALL load the E-stage values; ALU_ResultM SHALL take the mul/div result in DONE and the ALU result otherwise.
REQ-036 Operands latched on entry to RUN SHALL be unaffected by later changes on the forwarding inputs or ResultW.
REQ-037 Throughput SHALL be one non-mul/div instruction per cycle.
REQ-038 A mul/div instruction immediately following another SHALL start in the cycle after DONE.

Reset
REQ-039 When rst=0, the FSM SHALL go to IDLE, the counter and operand/accumulator registers SHALL clear to 0, and all M outputs SHALL be 0.
REQ-040 This reset SHALL be immediate and independent of clk, including mid-operation in RUN or DONE; any in-flight result SHALL be discarded.
REQ-041 After rst rises, the first posedge SHALL perform normal E/M capture.

Verification
REQ-042 ADD with ALUSrcE=0, RD1_E=5, RD2_E=7, RegWriteE=1, RD_E=3 -> next edge: ALU_ResultM=12, RD_M=3, RegWriteM=1.
REQ-043 Branch with BranchE=1, ALUControlE=001, SrcA=SrcB=9, PCE=0x100, Imm_Ext_E=0x20 -> PCSrcE=1, PCTargetE=0x120; with SrcB=8 -> PCSrcE=0.
REQ-044 ForwardA_E=10 with ALU_ResultM=0x10 and ForwardA_E=01 with ResultW=0x20, RD1_E=0 -> the ADD result reflects the forwarded value.
REQ-045 MUL 0xFFFFFFFF x 2 -> StallE high for 33 cycles, then ALU_ResultM=0xFFFFFFFE; MULHU of the same operands -> 0x00000001; RegWriteM=0 throughout the stall.
REQ-046 DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
REQ-047 Assert rst=0 at RUN counter 10 -> immediately StallE=0 and all M outputs 0; a fresh MUL after release completes correctly in 34 cycles.
